// File: rtl/ripple_count_monitor_if.sv
// Handshake/bus bundle between control logic and ripple_count_monitor.
// Ports: q_in/clear/cmp_en/cmp_val flow master->slave; count_valid,
// count_ext and the pulse/sticky flags flow slave->master.
interface ripple_count_monitor_if #(
  parameter int EXT_W = 12
);
  logic [3:0]       q_in;
  logic             clear;
  logic             cmp_en;
  logic [EXT_W-1:0] cmp_val;
  logic             count_valid;
  logic [EXT_W-1:0] count_ext;
  logic             wrap_pulse;
  logic             match_pulse;
  logic             restart_pulse;
  logic             step_err;
  logic             err_sticky;

  modport master (
    output q_in, clear, cmp_en, cmp_val,
    input  count_valid, count_ext, wrap_pulse, match_pulse,
           restart_pulse, step_err, err_sticky
  );

  modport slave (
    input  q_in, clear, cmp_en, cmp_val,
    output count_valid, count_ext, wrap_pulse, match_pulse,
           restart_pulse, step_err, err_sticky
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Ripple counter monitor: synchronises and de-glitches a 4-bit ripple count,
// extends it with a wrap count and flags restarts/illegal jumps.
// Latency: value stable before E0 is accepted at E(SYNC_STAGES+STABLE_CYCLES-1).
// Ports: clk, reset_n (async active-low), bus (slave modport of the _if).
module ripple_count_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int EXT_W         = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ripple_count_monitor_if.slave bus
);

  localparam logic [2:0] STABLE = 3'(STABLE_CYCLES);

  typedef enum logic {IDLE, TRACK} state_t;

  // Synchroniser chain plus a fill marker, so the all-zero reset contents
  // of the chain are never mistaken for a sampled counter value.
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill;
  logic [3:0]             s_q;
  logic                   s_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill <= '0;
    end else begin
      sync_q[0] <= bus.q_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s_q   = sync_q[SYNC_STAGES-1];
  assign s_vld = fill[SYNC_STAGES-1];

  // Stability filter.
  logic [3:0] cand;
  logic [2:0] run;
  logic [2:0] run_nxt;
  logic       same;
  logic       accept;

  assign same    = (s_q == cand);
  assign run_nxt = same ? ((run == STABLE) ? run : run + 3'd1) : 3'd1;
  // A saturated run on an unchanged value has already been accepted once.
  assign accept  = s_vld && (run_nxt == STABLE) && !(same && (run == STABLE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= '0;
      run  <= '0;
    end else if (s_vld) begin
      cand <= s_q;
      run  <= run_nxt;
    end
  end

  // Tracking decode of an accepted value against the current low nibble.
  state_t           state;
  logic [EXT_W-1:0] count_ext;
  logic             count_valid;
  logic             wrap_pulse, match_pulse, restart_pulse, step_err, err_sticky;
  logic [3:0]       acc;
  logic [EXT_W-1:0] ext_nxt;
  logic             changed, wrap_ev, rst_ev, err_ev;

  assign acc = count_ext[3:0];

  always_comb begin
    ext_nxt = count_ext;
    changed = 1'b0;
    wrap_ev = 1'b0;
    rst_ev  = 1'b0;
    err_ev  = 1'b0;
    if (accept && (s_q != acc)) begin
      changed = 1'b1;
      if ((acc != 4'd15) && (s_q == acc + 4'd1)) begin
        ext_nxt = {count_ext[EXT_W-1:4], s_q};
      end else if ((acc == 4'd15) && (s_q == 4'd0)) begin
        // Carry out of the nibble lands in the wrap count; the top wraps freely.
        ext_nxt = count_ext + EXT_W'(1);
        wrap_ev = 1'b1;
      end else if (s_q == 4'd0) begin
        ext_nxt = '0;
        rst_ev  = 1'b1;
      end else begin
        ext_nxt = {count_ext[EXT_W-1:4], s_q};
        err_ev  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count_ext     <= '0;
      count_valid   <= 1'b0;
      wrap_pulse    <= 1'b0;
      match_pulse   <= 1'b0;
      restart_pulse <= 1'b0;
      step_err      <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      wrap_pulse    <= 1'b0;
      match_pulse   <= 1'b0;
      restart_pulse <= 1'b0;
      step_err      <= 1'b0;
      if (bus.clear) begin
        // Clear wins over a same-edge acceptance; that value is dropped.
        state       <= IDLE;
        count_ext   <= '0;
        count_valid <= 1'b0;
        err_sticky  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              count_ext   <= EXT_W'(s_q);
              count_valid <= 1'b1;
              state       <= TRACK;
            end
          end
          TRACK: begin
            if (changed) begin
              count_ext     <= ext_nxt;
              wrap_pulse    <= wrap_ev;
              restart_pulse <= rst_ev;
              step_err      <= err_ev;
              err_sticky    <= err_sticky | err_ev;
              match_pulse   <= bus.cmp_en && (ext_nxt == bus.cmp_val);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.count_ext     = count_ext;
  assign bus.count_valid   = count_valid;
  assign bus.wrap_pulse    = wrap_pulse;
  assign bus.match_pulse   = match_pulse;
  assign bus.restart_pulse = restart_pulse;
  assign bus.step_err      = step_err;
  assign bus.err_sticky    = err_sticky;

endmodule

// File: tb/tb_ripple_count_monitor.sv
module tb_ripple_count_monitor;
  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 2;
  localparam int EXT_W         = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ripple_count_monitor_if #(.EXT_W(EXT_W)) bus ();

  ripple_count_monitor #(
    .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .EXT_W(EXT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: history of q_in samples since reset, plus expected outputs.
  int qh[$];
  bit m_valid, m_wrap, m_match, m_restart, m_err, m_sticky;
  int m_ext;
  int n_wrap, n_match, n_restart, n_err;
  int last_match_ext;
  int cur_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    qh.delete();
    m_valid = 0; m_wrap = 0; m_match = 0; m_restart = 0; m_err = 0; m_sticky = 0;
    m_ext = 0;
  endtask

  task automatic zero_counts();
    n_wrap = 0; n_match = 0; n_restart = 0; n_err = 0; last_match_ext = -1;
  endtask

  // A value is accepted when the sample seen at the end of the synchroniser
  // has just completed a streak of exactly STABLE_CYCLES equal samples.
  function automatic bit model_accept(output int v);
    int j;
    v = 0;
    j = qh.size() - 1 - SYNC_STAGES;
    if (j < STABLE_CYCLES - 1) return 1'b0;
    for (int i = 1; i < STABLE_CYCLES; i++)
      if (qh[j-i] != qh[j]) return 1'b0;
    if (j - STABLE_CYCLES >= 0 && qh[j-STABLE_CYCLES] == qh[j]) return 1'b0;
    v = qh[j];
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit acc;
    int v, lo;
    bit clr, cen;
    int cv;
    clr = bus.clear; cen = bus.cmp_en; cv = int'(bus.cmp_val);
    qh.push_back(int'(bus.q_in));
    acc = model_accept(v);
    m_wrap = 0; m_match = 0; m_restart = 0; m_err = 0;
    if (clr) begin
      m_valid = 0; m_ext = 0; m_sticky = 0;
    end else if (acc) begin
      if (!m_valid) begin
        m_valid = 1;
        m_ext = v;
      end else begin
        lo = m_ext % 16;
        if (v != lo) begin
          if (lo != 15 && v == lo + 1) m_ext = m_ext + 1;
          else if (lo == 15 && v == 0) begin
            m_ext = (m_ext + 1) % (1 << EXT_W);
            m_wrap = 1;
          end else if (v == 0) begin
            m_ext = 0;
            m_restart = 1;
          end else begin
            m_ext = m_ext - lo + v;
            m_err = 1;
            m_sticky = 1;
          end
          m_match = cen && (m_ext == cv);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_zero();
    else model_edge();
    #1;
    chk("count_valid", bus.count_valid, m_valid);
    chk("count_ext", bus.count_ext, m_ext);
    chk("wrap_pulse", bus.wrap_pulse, m_wrap);
    chk("match_pulse", bus.match_pulse, m_match);
    chk("restart_pulse", bus.restart_pulse, m_restart);
    chk("step_err", bus.step_err, m_err);
    chk("err_sticky", bus.err_sticky, m_sticky);
    n_wrap    += int'(bus.wrap_pulse);
    n_match   += int'(bus.match_pulse);
    n_restart += int'(bus.restart_pulse);
    n_err     += int'(bus.step_err);
    if (bus.match_pulse) last_match_ext = int'(bus.count_ext);
  endtask

  task automatic hold(input int v, input int n);
    bus.q_in = 4'(v);
    cur_q = v;
    repeat (n) tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.count_valid, 0);
    chk({tag, "_ext"}, bus.count_ext, 0);
    chk({tag, "_pulses"}, {bus.wrap_pulse, bus.match_pulse, bus.restart_pulse, bus.step_err}, 0);
    chk({tag, "_sticky"}, bus.err_sticky, 0);
  endtask

  task automatic count_run();
    hold(0, 4);
    for (int v = 1; v < 16; v++) hold(v, 4);
    hold(0, 4); hold(1, 4); hold(2, 4);
  endtask

  initial begin
    bus.q_in = 4'd0; bus.clear = 1'b0; bus.cmp_en = 1'b0; bus.cmp_val = '0;
    cur_q = 0;
    model_zero();
    zero_counts();

    // Reset state, then a value held from before the first edge.
    #12;
    chk_all_zero("reset");
    bus.q_in = 4'd5;
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t1_not_yet", bus.count_valid, 0);
    tick();
    chk("t1_valid", bus.count_valid, 1);
    chk("t1_ext", bus.count_ext, 12'h005);
    chk("t1_no_pulses", n_wrap + n_match + n_restart + n_err, 0);

    // Full lap 0..15 then 0: one wrap.
    do_clear(); zero_counts();
    for (int v = 0; v < 16; v++) begin
      hold(v, 6);
      if (v == 15) chk("t2_ext_f", bus.count_ext, 12'h00F);
    end
    hold(0, 6);
    chk("t2_ext", bus.count_ext, 12'h010);
    chk("t2_wraps", n_wrap, 1);
    chk("t2_errs", n_err, 0);

    // Single-cycle glitch is filtered out.
    do_clear(); zero_counts();
    hold(7, 6);
    chk("t3_ext7", bus.count_ext, 12'h007);
    hold(6, 1);
    hold(8, 6);
    chk("t3_ext8", bus.count_ext, 12'h008);
    chk("t3_errs", n_err, 0);

    // Illegal jump, then clear.
    do_clear();
    hold(3, 6); zero_counts();
    hold(9, 6);
    chk("t4_errs", n_err, 1);
    chk("t4_sticky", bus.err_sticky, 1);
    chk("t4_lo", bus.count_ext[3:0], 4'd9);
    do_clear();
    chk("t4_clr_sticky", bus.err_sticky, 0);
    chk("t4_clr_valid", bus.count_valid, 0);

    // Compare match: enabled, then disabled, then on the initial load.
    do_clear(); zero_counts();
    bus.cmp_val = 12'h012; bus.cmp_en = 1'b1;
    count_run();
    chk("t5_matches", n_match, 1);
    chk("t5_match_ext", last_match_ext, 32'h012);
    bus.cmp_en = 1'b0;
    do_clear(); zero_counts();
    count_run();
    chk("t5_off_matches", n_match, 0);
    bus.cmp_en = 1'b1; bus.cmp_val = 12'h005;
    do_clear(); zero_counts();
    hold(5, 4);
    chk("t5_load_valid", bus.count_valid, 1);
    chk("t5_load_matches", n_match, 0);

    // Restart, then reset in the middle of filtering.
    do_clear();
    hold(10, 6); zero_counts();
    hold(0, 6);
    chk("t6_restarts", n_restart, 1);
    chk("t6_ext", bus.count_ext, 0);
    chk("t6_errs", n_err, 0);
    hold(4, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("t6_async");
    model_zero();
    repeat (2) tick();
    reset_n = 1'b1;
    hold(4, 6);
    chk("t6_reload", bus.count_ext, 12'h004);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5) do_clear();
      else if (r < 10) begin
        bus.cmp_en = 1'($urandom_range(0, 1));
        bus.cmp_val = EXT_W'($urandom_range(0, 63));
      end else if (r < 65) hold((cur_q + 1) % 16, int'($urandom_range(1, 4)));
      else hold(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
Downstream consumer of the 4-bit ripple counter output. Synchronises the asynchronous, glitch-prone ripple value into the system clock domain and filters out transient ripple codes. Tracks legal +1 steps, extends the 4-bit count with a wrap count, and flags illegal jumps. Emits terminal-count, compare-match and error pulses for control logic.

Parameters:
SYNC_STAGES, 2, synchroniser depth on q_in (legal range 2..4)
STABLE_CYCLES, 2, consecutive identical synchronised samples required before a value is accepted (legal range 1..7)
EXT_W, 12, width of extended count; upper EXT_W-4 bits are the wrap count (EXT_W > 4)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
q_in  in  4  raw ripple counter output; asynchronous to clk
clear  in  1  synchronous clear of tracking state; sampled on the rising edge
cmp_en  in  1  enables compare-match detection
cmp_val  in  EXT_W  compare value for count_ext
count_valid  out  1  high once the first value has been accepted since reset or clear
count_ext  out  EXT_W  {wrap_count, accepted 4-bit value}
wrap_pulse  out  1  one-cycle pulse on an accepted 15->0 step
match_pulse  out  1  one-cycle pulse when count_ext becomes equal to cmp_val
restart_pulse  out  1  one-cycle pulse when the counter is seen to restart (jump to 0 from a value other than 15)
step_err  out  1  one-cycle pulse on an illegal accepted transition
err_sticky  out  1  latched on any step_err; cleared only by reset_n or clear

Behaviour:
- Reset (reset_n low, asynchronous):
  - All synchroniser, filter and tracking registers are 0.
  - All outputs are 0.
  - The state machine is in IDLE.
- Synchroniser: q_in passes through a SYNC_STAGES flop chain; the last stage is s_q.
- Stability filter:
  - cand holds the previous s_q; run counts consecutive edges with s_q == cand, saturating at STABLE_CYCLES.
  - When s_q differs from cand, run is set to 1.
  - A value is accepted on the edge where run reaches STABLE_CYCLES.
  - Each distinct value is accepted at most once; re-acceptance requires s_q to change first.
- Latency: if q_in is stable from before edge E0, acceptance and all output updates occur at edge E(SYNC_STAGES+STABLE_CYCLES-1). With default parameters that is E3.
- State machine:
  - IDLE: the first accepted value v loads count_ext = {0, v}, sets count_valid, and moves to TRACK. No pulses are generated on this first acceptance.
  - TRACK: acted on only when an accepted value new differs from the current low nibble acc. Cases:
    - new == acc+1 and acc != 15: low nibble <= new.
    - acc == 15 and new == 0: low nibble <= 0; wrap_count increments modulo 2^(EXT_W-4); wrap_pulse asserted.
    - new == 0 and acc != 15: count_ext <= 0; restart_pulse asserted; no error.
    - Any other value: low nibble <= new; wrap_count unchanged; step_err pulsed; err_sticky set.
  - clear: forces IDLE and zeroes count_ext, count_valid and err_sticky. It has priority over a simultaneous acceptance; that accepted value is discarded. The synchroniser and filter are not cleared.
- match_pulse:
  - Asserted for one cycle on the edge where count_ext is updated to a value equal to cmp_val, with cmp_en high.
  - Not asserted while count_ext stays constant.
  - Not asserted on the IDLE->TRACK load.
- Pulse timing: all pulses are registered, high for exactly one clk cycle after the update edge, and never asserted in IDLE.
- Reset mid-operation: asynchronous return to reset values regardless of state or in-flight filter count.

Test Plan:
1. Reset, then q_in held at 5 → count_valid=1 and count_ext=0x005 after 4 edges; no pulses.
2. q_in stepped 0→15→0, each value held 6 cycles → count_ext reaches 0x00F, then 0x010; one wrap_pulse.
3. q_in glitch 7→6→8, with 6 held 1 cycle only → 6 never accepted; count_ext goes 0x007→0x008; step_err=0.
4. q_in jump 3→9 → step_err pulses once; err_sticky=1; count_ext low nibble=9. Then clear → err_sticky=0, count_valid=0.
5. cmp_val=0x012, cmp_en=1, counter run from 0 → exactly one match_pulse, in the cycle count_ext becomes 0x012. With cmp_en=0 → no pulse.
6. q_in jump 10→0 → restart_pulse, count_ext=0. reset_n asserted mid-filter → all outputs 0 immediately.
